execute_stage_muldiv: RTL

Parametrised RV32IM/RV64IM execute stage: operand forwarding, single-cycle integer ALU, branch-target adder and EX/MEM pipeline register, extended with an iterative multiply/divide unit for the M extension. Sits between the ID/EX register and the MEM stage. While an M-extension op runs, it raises a stall request to the hazard unit and inserts bubbles into MEM. Adds XLEN generalisation, flush, valid tracking and multi-cycle operation.

---
 rtl/execute_stage_muldiv_if.sv | 60 ++++++
 rtl/execute_stage_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_muldiv_if
// Description : ID/EX inputs and EX/MEM outputs of the execute stage.
//               The master side drives the E-stage fields and the slave side
//               (the execute stage) drives the stall request and M-stage fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_muldiv_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              validE;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              ALUSrcE;
  logic [2:0]        ALUControlE;
  logic              MulDivE;
  logic [2:0]        funct3E;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   ResultW;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic              MemWriteE;
  logic [1:0]        ResultSrcE;

  logic              BusyE;
  logic              ZeroE;
  logic [XLEN-1:0]   PCTargetE;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [XLEN-1:0]   PCPlus4M;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              validM;
  logic [1:0]        ResultSrcM;

  modport master (
    output validE, FlushE, ForwardAE, ForwardBE, ALUSrcE, ALUControlE, MulDivE,
           funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE, RegWriteE,
           MemWriteE, ResultSrcE,
    input  BusyE, ZeroE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, validM, ResultSrcM
  );

  modport slave (
    input  validE, FlushE, ForwardAE, ForwardBE, ALUSrcE, ALUControlE, MulDivE,
           funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE, RegWriteE,
           MemWriteE, ResultSrcE,
    output BusyE, ZeroE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, validM, ResultSrcM
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_muldiv
// Description : RV32IM/RV64IM execute stage. Operand forwarding, single-cycle
//               ALU, branch-target adder, EX/MEM register and an iterative
//               radix-2 multiply/divide unit that stalls the front end.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_muldiv #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  wire logic            clk,
  input  wire logic            reset,
  execute_stage_muldiv_if.slave bus
);
  localparam int c_SHW = $clog2(XLEN);
  localparam int c_CW  = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CW-1:0]     r_cnt;
  logic [2*XLEN-1:0]   r_p;        // product, or {remainder, quotient}
  logic [XLEN-1:0]     r_m;        // multiplicand, or divisor
  logic [2:0]          r_f3;
  logic                r_neg, r_negr, r_divz;
  logic [REG_AW-1:0]   r_rd;
  logic                r_regwrite, r_memwrite;
  logic [1:0]          r_resultsrc;
  logic [XLEN-1:0]     r_wdata, r_pcplus4;

  logic [XLEN-1:0]     r_alu_m, r_wd_m, r_pc4_m;
  logic [REG_AW-1:0]   r_rd_m;
  logic                r_regwrite_m, r_memwrite_m, r_valid_m;
  logic [1:0]          r_resultsrc_m;

  logic [XLEN-1:0]     w_fwd_a, w_fwd_b, w_src_b, w_alu;
  logic [c_SHW-1:0]    w_shamt;
  logic                w_start, w_busy, w_bubble;
  logic                w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_abs_a, w_abs_b;
  logic [XLEN:0]       w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_q, w_r, w_mres;

  // Operand forwarding muxes; code 11 behaves like 00
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   w_fwd_a = bus.ResultW;
      2'b10:   w_fwd_a = r_alu_m;
      default: w_fwd_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      2'b01:   w_fwd_b = bus.ResultW;
      2'b10:   w_fwd_b = r_alu_m;
      default: w_fwd_b = bus.RD2E;
    endcase
  end

  assign w_src_b = bus.ALUSrcE ? bus.ImmExtE : w_fwd_b;
  assign w_shamt = w_src_b[c_SHW-1:0];

  // Single-cycle integer ALU
  always_comb begin
    case (bus.ALUControlE)
      3'b000:  w_alu = w_fwd_a + w_src_b;
      3'b001:  w_alu = w_fwd_a - w_src_b;
      3'b010:  w_alu = w_fwd_a & w_src_b;
      3'b011:  w_alu = w_fwd_a | w_src_b;
      3'b100:  w_alu = w_fwd_a ^ w_src_b;
      3'b101:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_src_b))};
      3'b110:  w_alu = w_fwd_a << w_shamt;
      default: w_alu = w_fwd_a >> w_shamt;
    endcase
  end

  assign w_start  = (r_state == S_IDLE) & bus.validE & ~bus.FlushE & bus.MulDivE;
  assign w_busy   = w_start | (r_state == S_RUN);
  assign w_bubble = bus.FlushE | ((r_state == S_IDLE) & (~bus.validE | w_busy)) |
                    (r_state == S_RUN);

  // Operand signedness: divides are signed when funct3[0]==0; MULHU is fully
  // unsigned and MULHSU treats only rs2 as unsigned. MUL low bits are sign-agnostic.
  assign w_a_signed = bus.funct3E[2] ? ~bus.funct3E[0] : (bus.funct3E[1:0] != 2'b11);
  assign w_b_signed = bus.funct3E[2] ? ~bus.funct3E[0] : ~bus.funct3E[1];
  assign w_a_neg    = w_a_signed & w_fwd_a[XLEN-1];
  assign w_b_neg    = w_b_signed & w_fwd_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -w_fwd_a : w_fwd_a;
  assign w_abs_b    = w_b_neg ? -w_fwd_b : w_fwd_b;

  // One shift-add step and one restoring-divide step
  assign w_mul_sum = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
  assign w_rem_sh  = r_p[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_m};

  // Sign fix-up and result select; divide-by-zero quotient bypasses the fix-up
  assign w_prod = r_neg ? -r_p : r_p;
  assign w_q    = r_divz ? {XLEN{1'b1}} : (r_neg ? -r_p[XLEN-1:0] : r_p[XLEN-1:0]);
  assign w_r    = r_negr ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN];
  assign w_mres = r_f3[2] ? (r_f3[1] ? w_r : w_q)
                          : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  // M-unit state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // M-unit next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (bus.FlushE) w_state_nxt = S_IDLE;
               else if (r_cnt == '0) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // M-unit operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0; r_p <= '0; r_m <= '0; r_f3 <= '0;
      r_neg <= 1'b0; r_negr <= 1'b0; r_divz <= 1'b0;
      r_rd <= '0; r_regwrite <= 1'b0; r_memwrite <= 1'b0; r_resultsrc <= '0;
      r_wdata <= '0; r_pcplus4 <= '0;
    end else if (w_start) begin
      r_cnt       <= c_CW'(XLEN-1);
      r_f3        <= bus.funct3E;
      r_neg       <= w_a_neg ^ w_b_neg;
      r_negr      <= w_a_neg;
      r_divz      <= (w_fwd_b == '0);
      r_p         <= {{XLEN{1'b0}}, (bus.funct3E[2] ? w_abs_a : w_abs_b)};
      r_m         <= bus.funct3E[2] ? w_abs_b : w_abs_a;
      r_rd        <= bus.RdE;
      r_regwrite  <= bus.RegWriteE;
      r_memwrite  <= bus.MemWriteE;
      r_resultsrc <= bus.ResultSrcE;
      r_wdata     <= w_fwd_b;
      r_pcplus4   <= bus.PCPlus4E;
    end else if (r_state == S_RUN) begin
      if (bus.FlushE) begin
        r_cnt <= '0;
      end else begin
        if (r_f3[2]) begin
          if (!w_diff[XLEN]) r_p <= {w_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
          else               r_p <= {r_p[2*XLEN-2:0], 1'b0};
        end else begin
          r_p <= {w_mul_sum, r_p[XLEN-1:1]};
        end
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // EX/MEM pipeline register: bubble, M-unit result or ALU result
  always_ff @(posedge clk) begin
    if (!reset || w_bubble) begin
      r_alu_m <= '0; r_wd_m <= '0; r_pc4_m <= '0; r_rd_m <= '0;
      r_regwrite_m <= 1'b0; r_memwrite_m <= 1'b0; r_valid_m <= 1'b0; r_resultsrc_m <= '0;
    end else if (r_state == S_DONE) begin
      r_alu_m <= w_mres; r_wd_m <= r_wdata; r_pc4_m <= r_pcplus4; r_rd_m <= r_rd;
      r_regwrite_m <= r_regwrite; r_memwrite_m <= r_memwrite; r_valid_m <= 1'b1;
      r_resultsrc_m <= r_resultsrc;
    end else begin
      r_alu_m <= w_alu; r_wd_m <= w_fwd_b; r_pc4_m <= bus.PCPlus4E; r_rd_m <= bus.RdE;
      r_regwrite_m <= bus.RegWriteE; r_memwrite_m <= bus.MemWriteE; r_valid_m <= 1'b1;
      r_resultsrc_m <= bus.ResultSrcE;
    end
  end

  assign bus.BusyE      = w_busy;
  assign bus.ZeroE      = ~bus.MulDivE & (w_alu == '0);
  assign bus.PCTargetE  = bus.PCE + bus.ImmExtE;
  assign bus.ALUResultM = r_alu_m;
  assign bus.WriteDataM = r_wd_m;
  assign bus.PCPlus4M   = r_pc4_m;
  assign bus.RdM        = r_rd_m;
  assign bus.RegWriteM  = r_regwrite_m;
  assign bus.MemWriteM  = r_memwrite_m;
  assign bus.validM     = r_valid_m;
  assign bus.ResultSrcM = r_resultsrc_m;
endmodule
`default_nettype wire
